// File: rtl/pll_clock_manager.sv
// PLL supervisor: drives RESETB, qualifies a synchronised LOCK, retries on timeout,
// sequences the downstream reset and generates divided one-cycle clock enables.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PLL_RESET  | pll_resetb held low for PLL_RST_CYCLES cycles
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT cycles for lock_s
// STABLE     | lock_s must stay high for LOCK_STABLE consecutive cycles
// HOLD       | lock qualified, sys_reset held for RESET_HOLD more cycles
// RUN        | sys_reset released, strobes active
module pll_clock_manager #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int LOCK_STABLE    = 256,
    parameter int RESET_HOLD     = 16,
    parameter int NUM_STROBES    = 2,
    parameter int DIV_WIDTH      = 16,
    parameter logic [NUM_STROBES*DIV_WIDTH-1:0] STROBE_DIV = {16'd100, 16'd10},
    parameter int CNT_WIDTH      = 8
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   pll_locked,
    output logic                   pll_resetb,
    output logic                   sys_reset,
    output logic                   running,
    output logic [NUM_STROBES-1:0] strobe,
    output logic [2:0]             state,
    output logic [CNT_WIDTH-1:0]   loss_count,
    output logic [CNT_WIDTH-1:0]   retry_count
);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } fsm_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max_of(LOCK_STABLE, RESET_HOLD));
    localparam int TMR_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [TMR_W-1:0] RST_TC     = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_TC  = TMR_W'(LOCK_STABLE - 1);
    localparam logic [TMR_W-1:0] HOLD_TC    = TMR_W'(RESET_HOLD - 1);

    fsm_t             fsm_q, fsm_d;
    logic [TMR_W-1:0] cyc_q;
    logic             lock_meta, lock_s;
    logic             retry_inc, loss_inc;

    always_comb begin
        fsm_d     = fsm_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (fsm_q)
            ST_PLL_RESET: if (cyc_q == RST_TC) fsm_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over a retry.
                if (lock_s) begin
                    fsm_d = ST_STABLE;
                end else if (cyc_q == TIMEOUT_TC) begin
                    fsm_d     = ST_PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                  fsm_d = ST_WAIT_LOCK;
                else if (cyc_q == STABLE_TC)  fsm_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s)                  fsm_d = ST_WAIT_LOCK;
                else if (cyc_q == HOLD_TC)    fsm_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    fsm_d    = ST_PLL_RESET;
                    loss_inc = 1'b1;
                end
            end
            default: fsm_d = ST_PLL_RESET;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            fsm_q       <= ST_PLL_RESET;
            cyc_q       <= '0;
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            sys_reset   <= 1'b1;
            running     <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            fsm_q     <= fsm_d;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            sys_reset <= (fsm_d != ST_RUN);
            running   <= (fsm_d == ST_RUN);
            // RUN has no timed exit, so the counter idles at zero there.
            if ((fsm_d != fsm_q) || (fsm_q == ST_RUN))
                cyc_q <= '0;
            else
                cyc_q <= cyc_q + 1'b1;
            if (retry_inc && (retry_count != {CNT_WIDTH{1'b1}}))
                retry_count <= retry_count + 1'b1;
            if (loss_inc && (loss_count != {CNT_WIDTH{1'b1}}))
                loss_count <= loss_count + 1'b1;
        end
    end

    assign pll_resetb = (fsm_q != ST_PLL_RESET);
    assign state      = fsm_q;

    for (genvar i = 0; i < NUM_STROBES; i++) begin : g_strobe
        localparam logic [DIV_WIDTH-1:0] DIV    = STROBE_DIV[i*DIV_WIDTH +: DIV_WIDTH];
        // Divisors of 0 or 1 keep the counter at zero, so the channel fires every cycle.
        localparam logic [DIV_WIDTH-1:0] DIV_TC = (DIV <= 1) ? '0 : DIV - 1'b1;

        logic [DIV_WIDTH-1:0] div_cnt;
        logic                 hit;

        assign hit = (div_cnt == DIV_TC);

        always_ff @(posedge clock_in) begin
            if (reset)
                div_cnt <= '0;
            else if ((fsm_q != ST_RUN) || (fsm_d != ST_RUN) || hit)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end

        assign strobe[i] = (fsm_q == ST_RUN) && hit;
    end

endmodule

// File: tb/tb_pll_clock_manager.sv
// Directed bench for pll_clock_manager: a cycle-indexed vector table for bring-up and
// lock loss, plus hand-written sequences for resets, timeouts and saturation.
module tb_pll_clock_manager;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_resetb;
    logic       sys_reset;
    logic       running;
    logic [1:0] strobe;
    logic [2:0] state;
    logic [7:0] loss_count;
    logic [7:0] retry_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pll_clock_manager #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .LOCK_STABLE   (8),
        .RESET_HOLD    (4),
        .NUM_STROBES   (2),
        .DIV_WIDTH     (16),
        .STROBE_DIV    ({16'd3, 16'd1}),
        .CNT_WIDTH     (8)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .running    (running),
        .strobe     (strobe),
        .state      (state),
        .loss_count (loss_count),
        .retry_count(retry_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int         cyc;
        logic       lock;
        logic [2:0] st;
        logic       rb;
        logic       sr;
        logic       run;
        logic [1:0] stb;
        logic [7:0] loss;
        logic [7:0] retry;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, logic lk, logic [2:0] st, logic rb, logic sr,
                                logic run, logic [1:0] stb, logic [7:0] loss,
                                logic [7:0] retry);
        vec_t v;
        v.cyc = c; v.lock = lk; v.st = st; v.rb = rb; v.sr = sr;
        v.run = run; v.stb = stb; v.loss = loss; v.retry = retry;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic rb,
                              input logic sr, input logic run, input logic [1:0] stb,
                              input logic [7:0] loss, input logic [7:0] retry);
        chk({tag, ".state"},       32'(state),       32'(st));
        chk({tag, ".pll_resetb"},  32'(pll_resetb),  32'(rb));
        chk({tag, ".sys_reset"},   32'(sys_reset),   32'(sr));
        chk({tag, ".running"},     32'(running),     32'(run));
        chk({tag, ".strobe"},      32'(strobe),      32'(stb));
        chk({tag, ".loss_count"},  32'(loss_count),  32'(loss));
        chk({tag, ".retry_count"}, 32'(retry_count), 32'(retry));
    endtask

    task automatic step();
        @(negedge clock_in);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Holds reset for two edges; returns mid-cycle 0 (first cycle after the last reset edge).
    task automatic do_reset();
        @(negedge clock_in);
        reset      = 1'b1;
        pll_locked = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;

        // Nominal bring-up, lock loss in RUN after 20 cycles, relock with strobe phase restart
        vecs.push_back(mk( 0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk( 3, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk( 4, 0, 1, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk( 6, 1, 1, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk( 8, 1, 1, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk( 9, 1, 2, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk(16, 1, 2, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk(17, 1, 3, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk(20, 1, 3, 1, 1, 0, 2'b00, 0, 0));
        vecs.push_back(mk(21, 1, 4, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(22, 1, 4, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(23, 1, 4, 1, 0, 1, 2'b11, 0, 0));
        vecs.push_back(mk(24, 1, 4, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(25, 1, 4, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(26, 1, 4, 1, 0, 1, 2'b11, 0, 0));
        vecs.push_back(mk(29, 1, 4, 1, 0, 1, 2'b11, 0, 0));
        vecs.push_back(mk(41, 0, 4, 1, 0, 1, 2'b11, 0, 0));
        vecs.push_back(mk(43, 0, 4, 1, 0, 1, 2'b01, 0, 0));
        vecs.push_back(mk(44, 0, 0, 0, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(45, 1, 0, 0, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(47, 1, 0, 0, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(48, 1, 1, 1, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(49, 1, 2, 1, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(56, 1, 2, 1, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(57, 1, 3, 1, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(60, 1, 3, 1, 1, 0, 2'b00, 1, 0));
        vecs.push_back(mk(61, 1, 4, 1, 0, 1, 2'b01, 1, 0));
        vecs.push_back(mk(62, 1, 4, 1, 0, 1, 2'b01, 1, 0));
        vecs.push_back(mk(63, 1, 4, 1, 0, 1, 2'b11, 1, 0));
        vecs.push_back(mk(64, 1, 4, 1, 0, 1, 2'b01, 1, 0));

        do_reset();
        foreach (vecs[i]) begin
            run_to(vecs[i].cyc);
            pll_locked = vecs[i].lock;
            check_outs($sformatf("vec_c%0d", vecs[i].cyc), vecs[i].st, vecs[i].rb,
                       vecs[i].sr, vecs[i].run, vecs[i].stb, vecs[i].loss, vecs[i].retry);
        end

        // Reset during RUN
        run_to(65);
        reset      = 1'b1;
        pll_locked = 1'b0;
        step();
        check_outs("rst_in_run", 0, 0, 1, 0, 2'b00, 0, 0);
        reset = 1'b0;
        cyc   = 0;

        // Timeout retry, then lock arriving exactly on the second timeout cycle
        run_to(35);
        check_outs("wait_last", 1, 1, 1, 0, 2'b00, 0, 0);
        step();
        check_outs("timeout1", 0, 0, 1, 0, 2'b00, 0, 1);
        run_to(39);
        check_outs("retry_rst_end", 0, 0, 1, 0, 2'b00, 0, 1);
        step();
        check_outs("rewait", 1, 1, 1, 0, 2'b00, 0, 1);
        run_to(69);
        pll_locked = 1'b1;
        run_to(71);
        check_outs("tie_pre", 1, 1, 1, 0, 2'b00, 0, 1);
        step();
        check_outs("tie_stable", 2, 1, 1, 0, 2'b00, 0, 1);

        // One-cycle lock glitch in STABLE
        run_to(75);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        check_outs("glitch_c77", 2, 1, 1, 0, 2'b00, 0, 1);
        step();
        check_outs("glitch_c78", 1, 1, 1, 0, 2'b00, 0, 1);
        step();
        check_outs("glitch_c79", 2, 1, 1, 0, 2'b00, 0, 1);
        run_to(86);
        check_outs("glitch_c86", 2, 1, 1, 0, 2'b00, 0, 1);
        step();
        check_outs("glitch_c87", 3, 1, 1, 0, 2'b00, 0, 1);

        // Reset during HOLD clears the retry count
        step();
        reset      = 1'b1;
        pll_locked = 1'b0;
        step();
        check_outs("rst_in_hold", 0, 0, 1, 0, 2'b00, 0, 0);
        reset = 1'b0;
        cyc   = 0;

        // 300 lock timeouts: retry_count saturates at 255
        run_to(36);
        check_outs("sat_t1", 0, 0, 1, 0, 2'b00, 0, 1);
        run_to(36 * 254);
        check_outs("sat_t254", 0, 0, 1, 0, 2'b00, 0, 254);
        run_to(36 * 255);
        check_outs("sat_t255", 0, 0, 1, 0, 2'b00, 0, 255);
        run_to(36 * 300 - 1);
        check_outs("sat_pre300", 1, 1, 1, 0, 2'b00, 0, 255);
        step();
        check_outs("sat_t300", 0, 0, 1, 0, 2'b00, 0, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
